// File: rtl/disp_pkg.sv
// Shared types, segment constants and the 7-segment decoder for the
// register display scanner.
package disp_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Ten BCD nibbles cover the full unsigned 32-bit range.
  localparam int BCD_NIBBLES = 10;
  localparam int BCD_W       = 4 * BCD_NIBBLES;
  localparam int BIN_W       = 32;

  // Decimal digit to active-low segment pattern; codes 10-15 never come
  // out of a valid BCD conversion and are shown dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, 32 shift
// cycles, then a single DONE cycle during which bcd holds the result.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              done,
  output logic              busy
);

  state_t             r_state;
  state_t             w_nextState;
  logic               w_load;
  logic               w_shiftEn;
  logic               w_done;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_adj;
  logic [4:0]         r_bitCnt;
  logic               r_busy;

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state and control strobes for the load / shift / done sequence.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shiftEn   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_shiftEn = 1'b1;
        if (r_bitCnt == 5'd0) w_nextState = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Add-3 correction on every nibble that is 5 or more before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Shift datapath, bit counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bcd    <= '0;
      r_bitCnt <= '0;
      r_busy   <= 1'b0;
    end else if (w_load) begin
      r_shift  <= bin;
      r_bcd    <= '0;
      r_bitCnt <= 5'd31;
      r_busy   <= 1'b1;
    end else if (w_shiftEn) begin
      {r_bcd, r_shift} <= {w_adj[BCD_W-2:0], r_shift, 1'b0};
      r_bitCnt         <= r_bitCnt - 5'd1;
    end else if (w_done) begin
      r_busy <= 1'b0;
    end
  end

  assign bcd  = r_bcd;
  assign done = w_done;
  assign busy = r_busy;

endmodule

// File: rtl/reg_display_scanner.sv
// Shows a CPU register value in decimal on a multiplexed active-low
// 7-segment display. The value is resynchronised, converted to BCD when it
// changes, and the digits are scanned at a programmable refresh rate.
module reg_display_scanner
  import disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       num,
  output logic [6:0]        seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [31:0]              r_s1;
  logic [31:0]              r_s2;
  logic [1:0]               r_primed;
  logic [31:0]              r_lastVal;
  logic                     r_first;
  logic                     w_qual;
  logic                     w_start;
  logic [BCD_W-1:0]         w_bcd;
  logic                     w_done;
  logic                     w_busy;
  logic                     w_ovf;
  logic [DIGITS-1:0][3:0]   r_digits;
  logic                     r_overflow;
  logic [CNT_W-1:0]         r_refCnt;
  logic [IDX_W-1:0]         r_idx;
  logic [DIGITS-1:0]        w_blank;
  logic                     w_zeroRun;
  logic [6:0]               w_segSel;
  logic [6:0]               r_segN;
  logic [DIGITS-1:0]        r_anN;

  // Two-stage capture of num; r_primed keeps the reset contents of the
  // stages from ever being mistaken for a stable input value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_primed <= '0;
    end else begin
      r_s1     <= num;
      r_s2     <= r_s1;
      r_primed <= {r_primed[0], 1'b1};
    end
  end

  assign w_qual  = r_primed[1] && (r_s1 == r_s2);
  assign w_start = !w_busy && w_qual && (r_first || (r_s2 != r_lastVal));

  // Remembers the last converted value; the first idle after reset always
  // converts so the display reflects num even when it equals the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastVal <= '0;
      r_first   <= 1'b1;
    end else if (w_start) begin
      r_lastVal <= r_s2;
      r_first   <= 1'b0;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (r_s2),
    .bcd   (w_bcd),
    .done  (w_done),
    .busy  (w_busy)
  );

  // Any nonzero nibble above the displayed digits means the value does not fit.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (i >= DIGITS) w_ovf = w_ovf | (|w_bcd[4*i +: 4]);
    end
  end

  // Display registers change only when a conversion completes, so a scan
  // never shows a mixture of old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else if (w_done) begin
      for (int i = 0; i < DIGITS; i++) r_digits[i] <= w_bcd[4*i +: 4];
      r_overflow <= w_ovf;
    end
  end

  // Leading-zero mask: a digit above digit 0 is dark when it and every
  // higher digit are zero.
  always_comb begin
    w_blank   = '0;
    w_zeroRun = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zeroRun  = w_zeroRun & (r_digits[i] == 4'd0);
      w_blank[i] = BLANK_LZ & (i > 0) & w_zeroRun;
    end
  end

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    w_segSel = seg_decode(r_digits[r_idx]);
    if (r_overflow)        w_segSel = SEG_DASH;
    else if (w_blank[r_idx]) w_segSel = SEG_BLANK;
  end

  // Refresh counter, digit index and registered pins; segments and anode
  // update on the same edge to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refCnt <= '0;
      r_idx    <= '0;
      r_segN   <= SEG_BLANK;
      r_anN    <= '1;
    end else begin
      if (r_refCnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_refCnt <= '0;
        r_idx    <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_refCnt <= r_refCnt + CNT_W'(1);
      end
      r_segN <= w_segSel;
      r_anN  <= ~(DIGITS'(1) << r_idx);
    end
  end

  assign seg_n    = r_segN;
  assign an_n     = r_anN;
  assign overflow = r_overflow;
  assign busy     = w_busy;

endmodule
